// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback port arbiter: two valid/ready sources, x0 filter, flush, registered write.
// Define WB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority with a req0 starvation counter.
module regfile_wb_arbiter #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [4:0]      req0_rd,
  input  logic [XLEN-1:0] req0_data,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [4:0]      req1_rd,
  input  logic [XLEN-1:0] req1_data,
  output logic            rd_valid,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] rd_data,
  output logic            grant_id
);

  localparam int unsigned REG_W = 5;

  logic x0_0, x0_1;
  logic live0, live1;
  logic gnt0, gnt1;

  // x0 writes are accepted immediately and never compete for the port
  assign x0_0  = !flush && req0_valid && (req0_rd == REG_W'(0));
  assign x0_1  = !flush && req1_valid && (req1_rd == REG_W'(0));
  assign live0 = !flush && req0_valid && (req0_rd != REG_W'(0));
  assign live1 = !flush && req1_valid && (req1_rd != REG_W'(0));

`ifdef WB_ROUND_ROBIN_EN
  logic ptr;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (live0 && live1) begin
      gnt0 = ptr;
      gnt1 = !ptr;
    end else begin
      gnt0 = live0;
      gnt1 = live1;
    end
  end

  // Pointer remembers the last non-x0 winner
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= 1'b0;
    end else if (gnt0 || gnt1) begin
      ptr <= gnt1;
    end
  end
`else
  localparam int unsigned CNT_W = 4;

  logic [CNT_W-1:0] wait_cnt;
  logic             starved;

  assign starved = (wait_cnt == CNT_W'(MAX_WAIT));

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (live0 && live1) begin
      gnt0 = starved;
      gnt1 = !starved;
    end else begin
      gnt0 = live0;
      gnt1 = live1;
    end
  end

  // Counts consecutive cycles req0 lost; cleared on grant, idle or flush
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (live0 && !gnt0) begin
      if (!starved) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
    end else begin
      wait_cnt <= '0;
    end
  end
`endif

  assign req0_ready = rst && (x0_0 || gnt0);
  assign req1_ready = rst && (x0_1 || gnt1);

  // Write register: rd/rd_data/grant_id hold when no grant
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid <= 1'b0;
      rd       <= '0;
      rd_data  <= '0;
      grant_id <= 1'b0;
    end else if (gnt0 || gnt1) begin
      rd_valid <= 1'b1;
      rd       <= gnt1 ? req1_rd : req0_rd;
      rd_data  <= gnt1 ? req1_data : req0_data;
      grant_id <= gnt1;
    end else begin
      rd_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter in its default fixed-priority build (MAX_WAIT=4).
module tb_regfile_wb_arbiter;

  localparam int unsigned XLEN = 32;

  logic            clk;
  logic            rst;
  logic            flush;
  logic            req0_valid, req0_ready;
  logic [4:0]      req0_rd;
  logic [XLEN-1:0] req0_data;
  logic            req1_valid, req1_ready;
  logic [4:0]      req1_rd;
  logic [XLEN-1:0] req1_data;
  logic            rd_valid;
  logic [4:0]      rd;
  logic [XLEN-1:0] rd_data;
  logic            grant_id;

  int n_vec;
  int n_err;

  logic [XLEN-1:0] regs [32];

  regfile_wb_arbiter #(.XLEN(XLEN), .MAX_WAIT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_rd    (req0_rd),
    .req0_data  (req0_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_rd    (req1_rd),
    .req1_data  (req1_data),
    .rd_valid   (rd_valid),
    .rd         (rd),
    .rd_data    (rd_data),
    .grant_id   (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model writes on the negedge following rd_valid
  always @(negedge clk) begin
    if (rd_valid) regs[rd] <= rd_data;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    flush      = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 32; i++) regs[i] = '0;
    rst        = 1'b0;
    flush      = 1'b0;
    req0_valid = 1'b1;
    req0_rd    = 5'd5;
    req0_data  = 32'h1234;
    req1_valid = 1'b0;
    req1_rd    = 5'd0;
    req1_data  = '0;

    // Reset state
    step();
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_rd", 64'(rd), 64'd0);
    check("rst_rd_data", 64'(rd_data), 64'd0);
    check("rst_grant_id", 64'(grant_id), 64'd0);
    check("rst_ready0", 64'(req0_ready), 64'd0);
    idle();
    #2 rst = 1'b1;
    step();
    check("post_rst_idle", 64'(rd_valid), 64'd0);

    // Single request from req0
    req0_valid = 1'b1; req0_rd = 5'd5; req0_data = 32'h1234;
    #1;
    check("single_ready0", 64'(req0_ready), 64'd1);
    check("single_ready1", 64'(req1_ready), 64'd0);
    step();
    idle();
    check("single_rd_valid", 64'(rd_valid), 64'd1);
    check("single_rd", 64'(rd), 64'd5);
    check("single_rd_data", 64'(rd_data), 64'h1234);
    check("single_grant_id", 64'(grant_id), 64'd0);
    step();
    check("single_drop", 64'(rd_valid), 64'd0);
    check("single_hold_rd", 64'(rd), 64'd5);

    // Contention: four req1 grants, then req0 forced, then counter cleared
    req0_valid = 1'b1; req0_rd = 5'd10; req0_data = 32'hA0;
    req1_valid = 1'b1; req1_rd = 5'd11; req1_data = 32'hB0;
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("cont_ready0_%0d", i), 64'(req0_ready), (i == 4) ? 64'd1 : 64'd0);
      check($sformatf("cont_ready1_%0d", i), 64'(req1_ready), (i == 4) ? 64'd0 : 64'd1);
      step();
      check($sformatf("cont_gid_%0d", i), 64'(grant_id), (i == 4) ? 64'd0 : 64'd1);
      check($sformatf("cont_data_%0d", i), 64'(rd_data), (i == 4) ? 64'hA0 : 64'hB0);
    end
    idle();
    step();

    // x0 filter
    req0_valid = 1'b1; req0_rd = 5'd0; req0_data = 32'hDEAD;
    req1_valid = 1'b1; req1_rd = 5'd7; req1_data = 32'hAA;
    #1;
    check("x0_ready0", 64'(req0_ready), 64'd1);
    check("x0_ready1", 64'(req1_ready), 64'd1);
    step();
    idle();
    check("x0_rd_valid", 64'(rd_valid), 64'd1);
    check("x0_rd", 64'(rd), 64'd7);
    check("x0_rd_data", 64'(rd_data), 64'hAA);
    step();
    check("x0_single_write", 64'(rd_valid), 64'd0);

    // Same destination: req1 first, req0 second, req0 value survives
    req0_valid = 1'b1; req0_rd = 5'd3; req0_data = 32'h11;
    req1_valid = 1'b1; req1_rd = 5'd3; req1_data = 32'h22;
    #1;
    check("same_ready1", 64'(req1_ready), 64'd1);
    step();
    req1_valid = 1'b0;
    check("same_first", 64'(rd_data), 64'h22);
    #1;
    check("same_ready0", 64'(req0_ready), 64'd1);
    step();
    req0_valid = 1'b0;
    check("same_second", 64'(rd_data), 64'h11);
    check("same_second_gid", 64'(grant_id), 64'd0);
    step();
    check("same_reg3", 64'(regs[3]), 64'h11);

    // Flush after four stalls: readies drop, write cleared, counter cleared
    req0_valid = 1'b1; req0_rd = 5'd12; req0_data = 32'hC0;
    req1_valid = 1'b1; req1_rd = 5'd13; req1_data = 32'hD0;
    for (int i = 0; i < 4; i++) step();
    check("pre_flush_valid", 64'(rd_valid), 64'd1);
    flush = 1'b1;
    #1;
    check("flush_ready0", 64'(req0_ready), 64'd0);
    check("flush_ready1", 64'(req1_ready), 64'd0);
    req0_rd = 5'd0;
    #1;
    check("flush_x0_ready0", 64'(req0_ready), 64'd0);
    req0_rd = 5'd12;
    step();
    flush = 1'b0;
    check("flush_rd_valid", 64'(rd_valid), 64'd0);
    #1;
    check("flush_cnt_clr0", 64'(req0_ready), 64'd0);
    check("flush_cnt_clr1", 64'(req1_ready), 64'd1);
    step();
    check("post_flush_gid", 64'(grant_id), 64'd1);

    // Reset mid-operation with a pending write
    check("mid_pending", 64'(rd_valid), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_valid", 64'(rd_valid), 64'd0);
    check("mid_rst_rd", 64'(rd), 64'd0);
    check("mid_rst_data", 64'(rd_data), 64'd0);
    check("mid_rst_ready1", 64'(req1_ready), 64'd0);
    idle();
    #2 rst = 1'b1;
    step();
    check("mid_after_rel", 64'(rd_valid), 64'd0);
    step();
    check("mid_after_rel2", 64'(rd_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
